// File: rtl/rv32_pkg.sv
// ---------------------------------------------------------------------------
// rv32_pkg
// Shared definitions for the RV32 core back end: data/register widths, load
// funct3 encodings, the writeback state enum and a misalignment helper.
// ---------------------------------------------------------------------------
package rv32_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    // Load size/sign encodings carried in funct3.
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MEM_WAIT = 2'd1,
        WRITE    = 2'd2
    } wb_state_t;

    // True when a load of the given size cannot be served from a single
    // naturally aligned access. Unused encodings behave as LW.
    function automatic logic load_misaligned(input logic [2:0] funct3,
                                             input logic [1:0] lane);
        logic mis;
        case (funct3)
            F3_LB, F3_LBU: mis = 1'b0;
            F3_LH, F3_LHU: mis = lane[0];
            default:       mis = (lane != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/load_align.sv
// ---------------------------------------------------------------------------
// load_align
// Combinational load data formatter: picks the byte/half lane out of the
// returned memory word and sign- or zero-extends it to a full word.
//
// Ports:
//   funct3  in   3     load size/sign encoding
//   addr    in   2     byte lane (effective address [1:0])
//   rdata   in   XLEN  raw memory word
//   result  out  XLEN  extended load value
// ---------------------------------------------------------------------------
module load_align
    import rv32_pkg::*;
(
    input  logic [2:0]      funct3,
    input  logic [1:0]      addr,
    input  logic [XLEN-1:0] rdata,
    output logic [XLEN-1:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        // NOTE: every output gets a value before the case so no path leaves it
        // unassigned; otherwise synthesis infers a latch.
        result   = rdata;
        byte_sel = rdata[7:0];
        half_sel = addr[1] ? rdata[31:16] : rdata[15:0];

        case (addr)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase

        case (funct3)
            F3_LB:   result = {{24{byte_sel[7]}}, byte_sel};
            F3_LH:   result = {{16{half_sel[15]}}, half_sel};
            F3_LBU:  result = {24'h0, byte_sel};
            F3_LHU:  result = {16'h0, half_sel};
            default: result = rdata;    // LW and the unused encodings
        endcase
    end

endmodule

// File: rtl/writeback_stage.sv
// ---------------------------------------------------------------------------
// writeback_stage
// Last RV32 pipeline stage in front of the register-file write port. Takes
// one retiring instruction per ex_valid/ex_ready handshake. ALU results are
// written one cycle later; loads issue one word read, wait for mem_rvalid,
// align/extend the data and write it the cycle after the response.
//
// Optional feature macro: WB_MISALIGN_CHECK_EN
//   defined   - misaligned LH/LHU/LW skip the read and pulse wb_err instead
//   undefined - no check; wb_err tied low
//
// Ports:
//   clk          in   1       core clock
//   reset        in   1       synchronous, active-low
//   ex_valid     in   1       execute has a retiring instruction
//   ex_ready     out  1       stage can accept (decoded from state/reset)
//   ex_rd        in   REG_AW  destination register
//   ex_reg_write in   1       instruction writes rd
//   ex_is_load   in   1       instruction is a load
//   ex_funct3    in   3       load size/sign
//   ex_result    in   XLEN    ALU result / load effective address
//   mem_req      out  1       one-cycle read request
//   mem_addr     out  XLEN    word-aligned read address
//   mem_rvalid   in   1       read data valid pulse
//   mem_rdata    in   XLEN    read data word
//   rf_a3        out  REG_AW  register-file write index
//   rf_wd3       out  XLEN    register-file write data
//   rf_we        out  1       register-file write strobe
//   wb_err       out  1       misaligned-load pulse
// ---------------------------------------------------------------------------
module writeback_stage
    import rv32_pkg::*;
#(
    parameter int XLEN   = rv32_pkg::XLEN,
    parameter int REG_AW = rv32_pkg::REG_AW
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_reg_write,
    input  logic              ex_is_load,
    input  logic [2:0]        ex_funct3,
    input  logic [XLEN-1:0]   ex_result,
    output logic              mem_req,
    output logic [XLEN-1:0]   mem_addr,
    input  logic              mem_rvalid,
    input  logic [XLEN-1:0]   mem_rdata,
    output logic [REG_AW-1:0] rf_a3,
    output logic [XLEN-1:0]   rf_wd3,
    output logic              rf_we,
    output logic              wb_err
);

    wb_state_t         state;
    logic [REG_AW-1:0] rd_q;
    logic [2:0]        funct3_q;
    logic [1:0]        lane_q;
    logic              reg_write_q;
    logic [XLEN-1:0]   load_data;
    logic              take;

`ifdef WB_MISALIGN_CHECK_EN
    logic wb_err_q;
    assign wb_err = wb_err_q;
`else
    assign wb_err = 1'b0;
`endif

    // Held low while reset is asserted so execute never hands over an
    // instruction that the reset would drop.
    assign ex_ready = reset && (state != MEM_WAIT);
    assign take     = ex_valid && ex_ready;

    load_align u_load_align (
        .funct3 (funct3_q),
        .addr   (lane_q),
        .rdata  (mem_rdata),
        .result (load_data)
    );

    // NOTE: all state here is assigned with <= so every register samples the
    // pre-edge values of the others, matching the hardware it describes.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            rd_q        <= '0;
            funct3_q    <= '0;
            lane_q      <= '0;
            reg_write_q <= 1'b0;
            mem_req     <= 1'b0;
            mem_addr    <= '0;
            rf_a3       <= '0;
            rf_wd3      <= '0;
            rf_we       <= 1'b0;
`ifdef WB_MISALIGN_CHECK_EN
            wb_err_q    <= 1'b0;
`endif
        end else begin
            // Strobes are single-cycle unless re-asserted below.
            mem_req <= 1'b0;
            rf_we   <= 1'b0;
`ifdef WB_MISALIGN_CHECK_EN
            wb_err_q <= 1'b0;
`endif
            case (state)
                IDLE, WRITE: begin
                    if (take && !ex_is_load) begin
                        rf_a3  <= ex_rd;
                        rf_wd3 <= ex_result;
                        rf_we  <= ex_reg_write && (ex_rd != '0);
                        state  <= WRITE;
                    end else if (take) begin
                        rd_q        <= ex_rd;
                        funct3_q    <= ex_funct3;
                        lane_q      <= ex_result[1:0];
                        reg_write_q <= ex_reg_write;
`ifdef WB_MISALIGN_CHECK_EN
                        if (load_misaligned(ex_funct3, ex_result[1:0])) begin
                            // No read is issued; the slot is spent flagging it.
                            wb_err_q <= 1'b1;
                            state    <= WRITE;
                        end else begin
                            mem_req  <= 1'b1;
                            mem_addr <= {ex_result[XLEN-1:2], 2'b00};
                            state    <= MEM_WAIT;
                        end
`else
                        mem_req  <= 1'b1;
                        mem_addr <= {ex_result[XLEN-1:2], 2'b00};
                        state    <= MEM_WAIT;
`endif
                    end else begin
                        state <= IDLE;
                    end
                end

                MEM_WAIT: begin
                    if (mem_rvalid) begin
                        rf_a3  <= rd_q;
                        rf_wd3 <= load_data;
                        rf_we  <= reg_write_q && (rd_q != '0);
                        state  <= WRITE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
